// File: rtl/rvfi_dmem_seq_if.sv
// Multi-channel RVFI memory-retirement bundle that feeds the in-order sequencer.
// The harness side drives it through master; the sequencer samples it through slave.
interface rvfi_dmem_seq_if #(
    parameter int NRET    = 2,
    parameter int XLEN    = 32,
    parameter int ORDER_W = 8
);
    logic [NRET-1:0]          rvfi_valid;
    logic [NRET*ORDER_W-1:0]  rvfi_order;
    logic [NRET*XLEN-1:0]     rvfi_mem_addr;
    logic [NRET*XLEN/8-1:0]   rvfi_mem_rmask;
    logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask;
    logic [NRET*XLEN-1:0]     rvfi_mem_rdata;
    logic [NRET*XLEN-1:0]     rvfi_mem_wdata;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_mem_addr,
               rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_mem_addr,
               rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
    );
endinterface

// File: rtl/rvfi_dmem_seq.sv
// Reorders RVFI memory records from NRET channels into one strictly ascending stream.
// Optional RVFI_DMEM_SEQ_MEMONLY_EN: records with no byte masks retire silently.
module rvfi_dmem_seq #(
    parameter int NRET    = 2,
    parameter int XLEN    = 32,
    parameter int ORDER_W = 8,
    parameter int DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    rvfi_dmem_seq_if.slave       rvfi,
    output logic                 out_valid,
    output logic [ORDER_W-1:0]   out_order,
    output logic [XLEN-1:0]      out_addr,
    output logic [XLEN/8-1:0]    out_rmask,
    output logic [XLEN/8-1:0]    out_wmask,
    output logic [XLEN-1:0]      out_rdata,
    output logic [XLEN-1:0]      out_wdata,
    output logic                 err_stale,
    output logic                 err_dup,
    output logic                 err_ovf
);
    localparam int MASK_W = XLEN / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ORDER_W-1:0] DEPTH_O = ORDER_W'(DEPTH);

    // ---------------- state ----------------
    logic [ORDER_W-1:0] next_order_reg;
    logic [DEPTH-1:0]   slot_valid_reg;
    logic [DEPTH-1:0]   slot_valid_next;

    logic [ORDER_W-1:0] slot_order_reg [DEPTH];
    logic [XLEN-1:0]    slot_addr_reg  [DEPTH];
    logic [MASK_W-1:0]  slot_rmask_reg [DEPTH];
    logic [MASK_W-1:0]  slot_wmask_reg [DEPTH];
    logic [XLEN-1:0]    slot_rdata_reg [DEPTH];
    logic [XLEN-1:0]    slot_wdata_reg [DEPTH];

    logic               out_valid_reg;
    logic [ORDER_W-1:0] out_order_reg;
    logic [XLEN-1:0]    out_addr_reg;
    logic [MASK_W-1:0]  out_rmask_reg;
    logic [MASK_W-1:0]  out_wmask_reg;
    logic [XLEN-1:0]    out_rdata_reg;
    logic [XLEN-1:0]    out_wdata_reg;

    logic err_stale_reg;
    logic err_dup_reg;
    logic err_ovf_reg;

    // ---------------- per-channel unpack and classification ----------------
    logic [ORDER_W-1:0] ch_order [NRET];
    logic [ORDER_W-1:0] ch_diff  [NRET];
    logic [IDX_W-1:0]   ch_idx   [NRET];
    logic [XLEN-1:0]    ch_addr  [NRET];
    logic [MASK_W-1:0]  ch_rmask [NRET];
    logic [MASK_W-1:0]  ch_wmask [NRET];
    logic [XLEN-1:0]    ch_rdata [NRET];
    logic [XLEN-1:0]    ch_wdata [NRET];

    logic [NRET-1:0] ch_accept;
    logic [NRET-1:0] ch_stale;
    logic [NRET-1:0] ch_ovf;
    logic [NRET-1:0] ch_dup;
    logic [NRET-1:0] ch_we;

    genvar gi;
    generate
        for (gi = 0; gi < NRET; gi++) begin : g_ch
            assign ch_order[gi] = rvfi.rvfi_order[gi*ORDER_W +: ORDER_W];
            assign ch_addr[gi]  = rvfi.rvfi_mem_addr[gi*XLEN +: XLEN];
            assign ch_rmask[gi] = rvfi.rvfi_mem_rmask[gi*MASK_W +: MASK_W];
            assign ch_wmask[gi] = rvfi.rvfi_mem_wmask[gi*MASK_W +: MASK_W];
            assign ch_rdata[gi] = rvfi.rvfi_mem_rdata[gi*XLEN +: XLEN];
            assign ch_wdata[gi] = rvfi.rvfi_mem_wdata[gi*XLEN +: XLEN];

            // Modular distance ahead of the retirement pointer; top half means behind it.
            assign ch_diff[gi]   = ch_order[gi] - next_order_reg;
            assign ch_idx[gi]    = ch_order[gi][IDX_W-1:0];
            assign ch_stale[gi]  = rvfi.rvfi_valid[gi] & ch_diff[gi][ORDER_W-1];
            assign ch_accept[gi] = rvfi.rvfi_valid[gi] & (ch_diff[gi] < DEPTH_O);
            assign ch_ovf[gi]    = rvfi.rvfi_valid[gi] & ~ch_stale[gi] & ~ch_accept[gi];
        end
    endgenerate

    // Inside the window, equal slot index implies equal order, so a slot hit is a duplicate.
    logic lower_hit;
    always_comb begin
        ch_dup    = '0;
        ch_we     = '0;
        lower_hit = 1'b0;
        for (int c = 0; c < NRET; c++) begin
            lower_hit = 1'b0;
            for (int l = 0; l < c; l++) begin
                if (ch_accept[l] && (ch_idx[l] == ch_idx[c])) begin
                    lower_hit = 1'b1;
                end
            end
            ch_dup[c] = ch_accept[c] & (slot_valid_reg[ch_idx[c]] | lower_hit);
            ch_we[c]  = ch_accept[c] & ~slot_valid_reg[ch_idx[c]] & ~lower_hit;
        end
    end

    // ---------------- drain ----------------
    logic [IDX_W-1:0] head_idx;
    logic             drain;
    logic             emit;

    assign head_idx = next_order_reg[IDX_W-1:0];
    assign drain    = slot_valid_reg[head_idx];

`ifdef RVFI_DMEM_SEQ_MEMONLY_EN
    assign emit = drain & ((|slot_rmask_reg[head_idx]) | (|slot_wmask_reg[head_idx]));
`else
    assign emit = drain;
`endif

    // A write can never land on the draining slot (that would need diff == DEPTH).
    always_comb begin
        slot_valid_next = slot_valid_reg;
        if (drain) begin
            slot_valid_next[head_idx] = 1'b0;
        end
        for (int c = 0; c < NRET; c++) begin
            if (ch_we[c]) begin
                slot_valid_next[ch_idx[c]] = 1'b1;
            end
        end
    end

    // Record payload storage; no reset needed because the valid bits gate every read.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NRET; c++) begin
            if (resetn && ch_we[c]) begin
                slot_order_reg[ch_idx[c]] <= ch_order[c];
                slot_addr_reg[ch_idx[c]]  <= ch_addr[c];
                slot_rmask_reg[ch_idx[c]] <= ch_rmask[c];
                slot_wmask_reg[ch_idx[c]] <= ch_wmask[c];
                slot_rdata_reg[ch_idx[c]] <= ch_rdata[c];
                slot_wdata_reg[ch_idx[c]] <= ch_wdata[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            next_order_reg <= '0;
            slot_valid_reg <= '0;
            out_valid_reg  <= 1'b0;
            out_order_reg  <= '0;
            out_addr_reg   <= '0;
            out_rmask_reg  <= '0;
            out_wmask_reg  <= '0;
            out_rdata_reg  <= '0;
            out_wdata_reg  <= '0;
            err_stale_reg  <= 1'b0;
            err_dup_reg    <= 1'b0;
            err_ovf_reg    <= 1'b0;
        end else begin
            slot_valid_reg <= slot_valid_next;
            if (drain) begin
                next_order_reg <= next_order_reg + 1'b1;
            end
            out_valid_reg <= emit;
            if (emit) begin
                out_order_reg <= slot_order_reg[head_idx];
                out_addr_reg  <= slot_addr_reg[head_idx];
                out_rmask_reg <= slot_rmask_reg[head_idx];
                out_wmask_reg <= slot_wmask_reg[head_idx];
                out_rdata_reg <= slot_rdata_reg[head_idx];
                out_wdata_reg <= slot_wdata_reg[head_idx];
            end
            err_stale_reg <= err_stale_reg | (|ch_stale);
            err_dup_reg   <= err_dup_reg   | (|ch_dup);
            err_ovf_reg   <= err_ovf_reg   | (|ch_ovf);
        end
    end

    assign out_valid = out_valid_reg;
    assign out_order = out_order_reg;
    assign out_addr  = out_addr_reg;
    assign out_rmask = out_rmask_reg;
    assign out_wmask = out_wmask_reg;
    assign out_rdata = out_rdata_reg;
    assign out_wdata = out_wdata_reg;
    assign err_stale = err_stale_reg;
    assign err_dup   = err_dup_reg;
    assign err_ovf   = err_ovf_reg;

endmodule

// File: doc/rvfi_dmem_seq.md
# rvfi_dmem_seq

In-order retirement sequencer for the formal harness. It collects memory-access records from all `NRET` RVFI retirement channels, reorders them by `rvfi_order`, and emits them one per cycle on a single channel in strictly ascending order. Single-channel data-memory consistency checkers depend on that order, so they sit downstream of this block. It also flags order-stream violations (stale, duplicate, out-of-window) as sticky error bits that the harness asserts low.

## Interface
- `NRET`, 2, number of retirement channels.
- `XLEN`, 32, data/address width; mask width is `XLEN/8`.
- `ORDER_W`, 8, width of `rvfi_order` per channel.
- `DEPTH`, 8, reorder window size; power of two, at most 2^(ORDER_W-1).

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `rvfi_valid`  in  NRET  per-channel retire strobe.
- `rvfi_order`  in  NRET*ORDER_W  retirement index.
- `rvfi_mem_addr`  in  NRET*XLEN  access address.
- `rvfi_mem_rmask`  in  NRET*XLEN/8  read byte mask.
- `rvfi_mem_wmask`  in  NRET*XLEN/8  write byte mask.
- `rvfi_mem_rdata`  in  NRET*XLEN  read data.
- `rvfi_mem_wdata`  in  NRET*XLEN  write data.
- `out_valid`  out  1  one in-order record valid this cycle.
- `out_order`, `out_addr`, `out_rmask`, `out_wmask`, `out_rdata`, `out_wdata`  out  single-channel record fields, same widths as the inputs.
- `err_stale`  out  1  sticky: an order arrived that was already retired.
- `err_dup`  out  1  sticky: an order arrived that is already buffered, or the same order arrived on two channels in one cycle.
- `err_ovf`  out  1  sticky: an order arrived beyond the window.

## Operation
- State:
  - `next_order` (ORDER_W bits).
  - `DEPTH` slots, each holding a valid bit plus the record fields. Slot index = `order[log2(DEPTH)-1:0]`.
- Classification, per valid channel:
  - Compute `diff = (order - next_order) mod 2^ORDER_W`.
  - `diff < DEPTH`: accept.
  - `diff >= 2^(ORDER_W-1)`: stale. Set `err_stale` and drop the record.
  - Otherwise: overflow. Set `err_ovf` and drop the record.
- Accept path:
  - If the target slot is already valid, or a lower-numbered channel targets the same slot this cycle, set `err_dup`. The lowest-numbered channel wins, and an already-buffered entry is never overwritten.
  - Otherwise write the record and set the slot's valid bit.
- Drain:
  - Each edge, if `slot[next_order]` is valid, copy it to the `out_*` registers, clear the slot, and increment `next_order` (wraps at 2^ORDER_W).
  - At most one drain per cycle.
  - If the slot is not valid, `out_valid` is 0 and `out_*` data holds its previous value.
- Simultaneous events:
  - An accepted write always targets a slot other than the one draining on the same edge. A write to the draining slot would need `diff = DEPTH`, which is classified as overflow.
  - A write and a drain on different slots in the same cycle both take effect.
- Error bits are sticky until reset and have no effect on accept/drain for other records.
- All inputs are ignored while `resetn` is low.

## Timing
- Reset values (synchronous, `resetn` low at an edge):
  - `next_order` = 0, all slot valid bits = 0.
  - `out_valid` and all `out_*` = 0.
  - `err_*` = 0.
- Reset asserted mid-operation discards every buffered record. Records presented in the first cycle after `resetn` rises are classified against `next_order = 0`.
- Latency:
  - A record sampled at edge k is written at edge k.
  - The earliest drain is at edge k+1, so `out_valid` is high in the cycle after edge k+1.
  - There is no bypass.
- Throughput is one output per cycle. A burst of `NRET` records per cycle accumulates in the window; sustained input above 1/cycle eventually raises `err_ovf`.
- Error bits rise in the cycle after the offending sample.

## Configuration
- `RVFI_DMEM_SEQ_MEMONLY_EN` defined:
  - A record with `rmask == 0` and `wmask == 0` still occupies its slot and still advances `next_order` on drain.
  - For such a record `out_valid` stays 0 and the `out_*` data registers are not updated.
- Not defined: every record is emitted regardless of masks.

## Test plan
- Reset, then ch0 presents order 0, addr 0x100, wmask 0xF, wdata 0xDEADBEEF. Required: `out_valid` high two cycles later with identical fields; `next_order` = 1.
- Same cycle, ch0 presents order 1 and ch1 presents order 0. Required: emits order 0 then order 1 on consecutive cycles; no error.
- Present orders 2, 3 while `next_order` = 0, then order 0, then order 1 in later cycles. Required: outputs 0, 1, 2, 3 in consecutive cycles once order 1 arrives.
- Present order 0 twice (second copy has different wdata). Required: `err_dup` = 1; emitted wdata is from the first copy. Then present order 0 again after it retired: `err_stale` = 1.
- With `next_order` = 0, present order 8 (`DEPTH` = 8). Required: `err_ovf` = 1; order 8 is never emitted. Drive `next_order` through 255 → 0: orders 254, 255, 0 emit in order with no errors.
- With `RVFI_DMEM_SEQ_MEMONLY_EN` defined, present order 0 with zero masks, then order 1 with rmask 0x3. Required: only order 1 produces `out_valid`; `next_order` = 2.
